// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_pkg -- shared definitions for the 4:1 mux scan controller.
//   state_t     : FSM state encoding (IDLE=0, SCAN=1)
//   NUM_CH/CH_W : number of mux channels and select width
//   lowest_ch() : lowest enabled channel in a mask
//   next_ch()   : next higher enabled channel, or wrap to the lowest with last=1
package mux_scan_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   typedef logic [CH_W-1:0]   ch_t;
   typedef logic [NUM_CH-1:0] mask_t;

   typedef struct packed {
      ch_t  ch;    // channel to select next
      logic last;  // no higher enabled channel: ch wrapped to the lowest one
   } next_ch_t;

   // Scanning from the top down leaves the lowest set bit as the result.
   function automatic ch_t lowest_ch(input mask_t mask);
      ch_t r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) r = ch_t'(i);
      end
      return r;
   endfunction

   function automatic next_ch_t next_ch(input mask_t mask, input ch_t ch);
      next_ch_t r;
      r.ch   = lowest_ch(mask);
      r.last = 1'b1;
      // Top-down scan so the closest higher enabled channel wins.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && (i > int'(ch))) begin
            r.ch   = ch_t'(i);
            r.last = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if -- command, mux and result signals of the scan controller.
//   start/stop/cont/en_mask : scan commands (master -> slave)
//   y                       : mux output sampled by the controller
//   s0/s1                   : mux selects, channel = {s1,s0}
//   word/word_valid         : captured word and its one-cycle strobe
//   busy                    : controller is scanning
// The slave modport is the controller; master is whoever drives commands
// and presents the mux output.
interface mux_scan_ctrl_if;
   import mux_scan_pkg::*;

   logic  start;
   logic  stop;
   logic  cont;
   mask_t en_mask;
   logic  y;
   logic  s0;
   logic  s1;
   mask_t word;
   logic  word_valid;
   logic  busy;

   modport master (
      output start, stop, cont, en_mask, y,
      input  s0, s1, word, word_valid, busy
   );

   modport slave (
      input  start, stop, cont, en_mask, y,
      output s0, s1, word, word_valid, busy
   );

endinterface

// File: rtl/mux_scan_ctrl_settle_counter.sv
// settle_counter -- dwell timer counting 1..SETTLE and wrapping back to 1.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (count -> 1)
//   clr  : restart the window (count -> 1)
//   en   : advance the count
//   done : count has reached SETTLE (last cycle of the window)
module settle_counter #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   logic [CNT_W-1:0] cnt_reg;

   assign done = (cnt_reg == CNT_W'(SETTLE));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_reg <= CNT_W'(1);
      end else if (en) begin
         cnt_reg <= done ? CNT_W'(1) : cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl -- round-robin scan controller for a 4:1 mux.
// Steps the mux selects through the enabled channels, holds each for SETTLE
// cycles, samples y on the last edge of the window and emits the assembled
// 4-bit word with a one-cycle valid strobe.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of mux_scan_ctrl_if (commands in, selects/word/status out)
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic           clk,
   input  logic           rst,
   mux_scan_ctrl_if.slave bus
);

   state_t   state_reg, state_next;
   ch_t      ch_reg;
   mask_t    mask_reg;
   logic     cont_reg;
   mask_t    shadow_reg;
   mask_t    word_reg;
   logic     valid_reg;

   logic     settle_done;
   logic     cnt_clr;
   logic     cnt_en;
   logic     do_start;
   logic     do_abort;
   logic     do_sample;
   logic     do_finish;
   logic     busy;
   next_ch_t nxt;
   mask_t    sample_vec;

   settle_counter #(.SETTLE(SETTLE)) u_settle (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .done (settle_done)
   );

   assign nxt = next_ch(mask_reg, ch_reg);

   // The current sample placed at the bit of the selected channel only;
   // disabled channels are never selected, so their bits stay 0.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sample
         assign sample_vec[gi] = bus.y && (ch_reg == ch_t'(gi));
      end
   endgenerate

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start && !bus.stop && (bus.en_mask != '0)) state_next = SCAN;
         end
         SCAN: begin
            if (bus.stop)                                     state_next = IDLE;
            else if (settle_done && nxt.last && !cont_reg)    state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs / datapath controls ----------------
   always_comb begin
      do_start  = 1'b0;
      do_abort  = 1'b0;
      do_sample = 1'b0;
      do_finish = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      busy      = 1'b0;
      case (state_reg)
         IDLE: begin
            // Holding the counter clear means every scan starts at count 1.
            cnt_clr  = 1'b1;
            do_start = bus.start && !bus.stop && (bus.en_mask != '0);
         end
         SCAN: begin
            busy = 1'b1;
            if (bus.stop) begin
               // stop wins over any sample/complete on the same edge.
               do_abort = 1'b1;
               cnt_clr  = 1'b1;
            end else begin
               cnt_en    = 1'b1;
               do_sample = settle_done;
               do_finish = settle_done && nxt.last;
            end
         end
         default: begin
            cnt_clr = 1'b1;
         end
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_reg     <= '0;
         mask_reg   <= '0;
         cont_reg   <= 1'b0;
         shadow_reg <= '0;
         word_reg   <= '0;
         valid_reg  <= 1'b0;
      end else begin
         valid_reg <= do_finish;
         if (do_start) begin
            mask_reg   <= bus.en_mask;
            cont_reg   <= bus.cont;
            ch_reg     <= lowest_ch(bus.en_mask);
            shadow_reg <= '0;
         end else if (do_abort) begin
            ch_reg <= '0;
         end else if (do_finish) begin
            word_reg   <= shadow_reg | sample_vec;
            shadow_reg <= '0;
            // On the last channel nxt.ch has already wrapped to the lowest one.
            ch_reg     <= cont_reg ? nxt.ch : '0;
         end else if (do_sample) begin
            shadow_reg <= shadow_reg | sample_vec;
            ch_reg     <= nxt.ch;
         end
      end
   end

   assign bus.s0         = ch_reg[0];
   assign bus.s1         = ch_reg[1];
   assign bus.word       = word_reg;
   assign bus.word_valid = valid_reg;
   assign bus.busy       = busy;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl with a behavioural 4:1 mux.
module tb_mux_scan_ctrl;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] din = 4'b0000;

   int errors = 0;
   int checks = 0;

   mux_scan_ctrl_if bus ();

   // The mux being scanned: y follows the selected input combinationally.
   assign bus.y = din[{bus.s1, bus.s0}];

   mux_scan_ctrl #(.SETTLE(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mask;
      logic [3:0] din;
      logic [3:0] exp_word;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One single-mode scan; inputs change and checks happen on negedges.
   // With disturb set, start is held and the mask is changed mid-scan.
   task automatic run_scan(input logic [3:0] mask, input logic [3:0] d,
                           input logic [3:0] exp_word, input bit disturb);
      int chs[$];
      int n;
      for (int c = 0; c < 4; c++) if (mask[c]) chs.push_back(c);
      n = chs.size();
      @(negedge clk);
      din = d; bus.en_mask = mask; bus.cont = 1'b0; bus.start = 1'b1;
      @(negedge clk);                       // just after E0
      bus.start = disturb;
      if (disturb) bus.en_mask = 4'b0001;
      for (int t = 0; t < n * S; t++) begin
         chk("scan_sel",   {bus.s1, bus.s0}, chs[t / S]);
         chk("scan_busy",  bus.busy, 1);
         chk("scan_valid", bus.word_valid, 0);
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("done_valid", bus.word_valid, 1);
      chk("done_word",  bus.word, exp_word);
      chk("done_busy",  bus.busy, 0);
      chk("done_sel",   {bus.s1, bus.s0}, 0);
      $display("scan mask=%b din=%b disturb=%0d word=%b", mask, d, disturb, bus.word);
      @(negedge clk);
      chk("post_valid", bus.word_valid, 0);
      chk("post_word",  bus.word, exp_word);
      chk("post_busy",  bus.busy, 0);
   endtask

   initial begin
      int pulses;

      vecs[0] = '{4'b1111, 4'b1011, 4'b1011};
      vecs[1] = '{4'b0101, 4'b1011, 4'b0001};
      vecs[2] = '{4'b1010, 4'b0101, 4'b0000};
      vecs[3] = '{4'b0110, 4'b0110, 4'b0110};
      vecs[4] = '{4'b1000, 4'b1011, 4'b1000};

      bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0; bus.en_mask = 4'b0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_sel",   {bus.s1, bus.s0}, 0);
      chk("rst_busy",  bus.busy, 0);
      chk("rst_word",  bus.word, 0);
      chk("rst_valid", bus.word_valid, 0);
      $display("reset released");

      // ---- table-driven single scans ----
      for (int v = 0; v < 5; v++) run_scan(vecs[v].mask, vecs[v].din, vecs[v].exp_word, 1'b0);

      // ---- reset mid-scan at E0+3 ----
      @(negedge clk);
      din = 4'b1011; bus.en_mask = 4'b1111; bus.start = 1'b1;
      @(negedge clk);                       // after E0
      bus.start = 1'b0;
      @(negedge clk);                       // after E0+1
      @(negedge clk);                       // after E0+2
      rst = 1'b1;
      @(negedge clk);                       // after E0+3
      rst = 1'b0;
      chk("midrst_sel",   {bus.s1, bus.s0}, 0);
      chk("midrst_busy",  bus.busy, 0);
      chk("midrst_word",  bus.word, 0);
      chk("midrst_valid", bus.word_valid, 0);
      $display("reset mid-scan word=%b busy=%b", bus.word, bus.busy);

      // ---- abort with stop at E0+5 ----
      run_scan(4'b1111, 4'b1011, 4'b1011, 1'b0);
      @(negedge clk);
      din = 4'b0100; bus.en_mask = 4'b1111; bus.start = 1'b1;
      @(negedge clk);                       // after E0
      bus.start = 1'b0;
      repeat (4) @(negedge clk);            // after E0+4
      bus.stop = 1'b1;
      @(negedge clk);                       // after E0+5
      bus.stop = 1'b0;
      chk("abort_busy",  bus.busy, 0);
      chk("abort_sel",   {bus.s1, bus.s0}, 0);
      chk("abort_valid", bus.word_valid, 0);
      chk("abort_word",  bus.word, 4'b1011);
      pulses = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (bus.word_valid) pulses++;
      end
      chk("abort_no_valid", pulses, 0);
      chk("abort_word_held", bus.word, 4'b1011);
      $display("abort word=%b pulses=%0d", bus.word, pulses);

      // ---- start with empty mask is ignored ----
      bus.en_mask = 4'b0000; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int t = 0; t < 3; t++) begin
         chk("zero_mask_busy", bus.busy, 0);
         @(negedge clk);
      end
      $display("start with mask=0000 busy=%b", bus.busy);

      // ---- start held and mask changed while busy ----
      run_scan(4'b1111, 4'b1011, 4'b1011, 1'b1);

      // ---- continuous mode, i2 raised before ch2's second-scan sample ----
      din = 4'b1011; bus.en_mask = 4'b1111; bus.cont = 1'b1; bus.start = 1'b1;
      @(negedge clk);                       // after E0
      bus.start = 1'b0; bus.cont = 1'b0;
      for (int t = 0; t <= 24; t++) begin
         chk("cont_busy", bus.busy, 1);
         chk("cont_sel",  {bus.s1, bus.s0}, (t % 8) / 2);
         if (t > 0 && (t % 8) == 0) begin
            chk("cont_valid", bus.word_valid, 1);
            chk("cont_word",  bus.word, (t == 8) ? 4'b1011 : 4'b1111);
            $display("cont word t=%0d word=%b", t, bus.word);
         end else begin
            chk("cont_valid_low", bus.word_valid, 0);
         end
         if (t == 9) din = 4'b1111;
         if (t == 24) bus.stop = 1'b1;
         @(negedge clk);
      end
      bus.stop = 1'b0;
      chk("cont_stop_busy",  bus.busy, 0);
      chk("cont_stop_valid", bus.word_valid, 0);
      chk("cont_stop_word",  bus.word, 4'b1111);
      $display("cont stopped busy=%b word=%b", bus.busy, bus.word);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
